// File: rtl/ariane_axi.sv
// AXI4 channel and bundle types shared by the cache memory port and the interconnect.
package ariane_axi;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ax_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     ar_ready;
    logic     w_ready;
    logic     b_valid;
    b_chan_t  b;
    logic     r_valid;
    r_chan_t  r;
  } resp_t;

endpackage

// File: rtl/wt_cache_pkg.sv
// Shared types for the write-through cache memory-side transaction limiter.
package wt_cache_pkg;

  typedef enum logic [1:0] {TL_RUN, TL_DRAIN, TL_IDLE} txn_lim_state_e;

  localparam int unsigned TXN_CNT_W = 8;

endpackage

// File: rtl/wt_txn_counter.sv
// Outstanding-burst counter: registered count, combinational next value and limit compare.
// A decrement at zero is a protocol error; the count holds and an assertion fires.
module wt_txn_counter
  import wt_cache_pkg::*;
#(
  parameter int unsigned Max = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 inc,
  input  logic                 dec,
  output logic [TXN_CNT_W-1:0] cnt,
  output logic [TXN_CNT_W-1:0] cnt_nxt,
  output logic                 below_max
);

  localparam logic [TXN_CNT_W-1:0] MaxCnt = TXN_CNT_W'(Max);

  logic [TXN_CNT_W-1:0] cnt_q;
  logic                 underflow;
  logic                 do_dec;

  assign underflow = dec & (cnt_q == '0);
  assign do_dec    = dec & ~underflow;

  always_comb begin
    cnt_nxt = cnt_q;
    case ({inc, do_dec})
      2'b10:   cnt_nxt = cnt_q + TXN_CNT_W'(1);
      2'b01:   cnt_nxt = cnt_q - TXN_CNT_W'(1);
      default: cnt_nxt = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_nxt;
  end

  assign cnt       = cnt_q;
  assign below_max = cnt_q < MaxCnt;

  no_underflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !underflow);

endmodule

// File: rtl/wt_axi_txn_limiter.sv
// Caps outstanding AXI read/write bursts and provides a drain/idle handshake; zero-latency pass-through.
// Only AR/AW valid/ready are gated; optional stall counters under WT_AXI_TXN_LIMITER_PERF_EN.
module wt_axi_txn_limiter
  import wt_cache_pkg::*;
#(
  parameter int unsigned MaxRdTxn = 8,
  parameter int unsigned MaxWrTxn = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  ariane_axi::req_t     slv_req_i,
  output ariane_axi::resp_t    slv_resp_o,
  output ariane_axi::req_t     mst_req_o,
  input  ariane_axi::resp_t    mst_resp_i,
  input  logic                 drain_req_i,
  output logic                 drain_ack_o,
  output logic [TXN_CNT_W-1:0] rd_cnt_o,
`ifdef WT_AXI_TXN_LIMITER_PERF_EN
  output logic [31:0]          rd_stall_cnt_o,
  output logic [31:0]          wr_stall_cnt_o,
`endif
  output logic [TXN_CNT_W-1:0] wr_cnt_o
);

  txn_lim_state_e       state_q, state_d;
  logic                 ar_pres_q, ar_pres_d, aw_pres_q, aw_pres_d;
  logic                 ar_ok, aw_ok;
  logic                 ar_hs, aw_hs, r_last_hs, b_hs;
  logic                 rd_below, wr_below;
  logic [TXN_CNT_W-1:0] rd_cnt_nxt, wr_cnt_nxt;
  logic                 drain_ack_q;

  // A presented address beat keeps its permission until accepted, whatever the limit or drain says.
  assign ar_ok = ar_pres_q | (rd_below & (state_q == TL_RUN));
  assign aw_ok = aw_pres_q | (wr_below & (state_q == TL_RUN));

  always_comb begin
    mst_req_o           = slv_req_i;
    mst_req_o.ar_valid  = slv_req_i.ar_valid & ar_ok;
    mst_req_o.aw_valid  = slv_req_i.aw_valid & aw_ok;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_ok;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_ok;
  end

  assign ar_hs     = mst_req_o.ar_valid & mst_resp_i.ar_ready;
  assign aw_hs     = mst_req_o.aw_valid & mst_resp_i.aw_ready;
  assign r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
  assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;

  assign ar_pres_d = ~ar_hs & (ar_pres_q | mst_req_o.ar_valid);
  assign aw_pres_d = ~aw_hs & (aw_pres_q | mst_req_o.aw_valid);

  wt_txn_counter #(.Max(MaxRdTxn)) i_rd_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .inc       (ar_hs),
    .dec       (r_last_hs),
    .cnt       (rd_cnt_o),
    .cnt_nxt   (rd_cnt_nxt),
    .below_max (rd_below)
  );

  wt_txn_counter #(.Max(MaxWrTxn)) i_wr_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .inc       (aw_hs),
    .dec       (b_hs),
    .cnt       (wr_cnt_o),
    .cnt_nxt   (wr_cnt_nxt),
    .below_max (wr_below)
  );

  // Idle is judged on next-state values so the state flips the same edge the last response retires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TL_RUN:   if (drain_req_i) state_d = TL_DRAIN;
      TL_DRAIN: begin
        if (!drain_req_i) state_d = TL_RUN;
        else if ((rd_cnt_nxt == '0) && (wr_cnt_nxt == '0) && !ar_pres_d && !aw_pres_d)
          state_d = TL_IDLE;
      end
      TL_IDLE:  if (!drain_req_i) state_d = TL_RUN;
      default:  state_d = TL_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= TL_RUN;
      ar_pres_q   <= 1'b0;
      aw_pres_q   <= 1'b0;
      drain_ack_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ar_pres_q   <= ar_pres_d;
      aw_pres_q   <= aw_pres_d;
      drain_ack_q <= (state_d == TL_IDLE);
    end
  end

  assign drain_ack_o = drain_ack_q;

`ifdef WT_AXI_TXN_LIMITER_PERF_EN
  logic [31:0] rd_stall_q, wr_stall_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_stall_q <= '0;
      wr_stall_q <= '0;
    end else begin
      if (slv_req_i.ar_valid && !ar_ok && (rd_stall_q != '1)) rd_stall_q <= rd_stall_q + 32'd1;
      if (slv_req_i.aw_valid && !aw_ok && (wr_stall_q != '1)) wr_stall_q <= wr_stall_q + 32'd1;
    end
  end

  assign rd_stall_cnt_o = rd_stall_q;
  assign wr_stall_cnt_o = wr_stall_q;
`endif

endmodule

// File: tb/tb_wt_axi_txn_limiter.sv
// Directed bench for wt_axi_txn_limiter with both limits set to 2.
module tb_wt_axi_txn_limiter;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  ariane_axi::req_t  slv_req;
  ariane_axi::resp_t slv_resp;
  ariane_axi::req_t  mst_req;
  ariane_axi::resp_t mst_resp;
  logic              drain_req;
  logic              drain_ack;
  logic [7:0]        rd_cnt, wr_cnt;
`ifdef WT_AXI_TXN_LIMITER_PERF_EN
  logic [31:0]       rd_stall, wr_stall;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  wt_axi_txn_limiter #(.MaxRdTxn(2), .MaxWrTxn(2)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .slv_req_i      (slv_req),
    .slv_resp_o     (slv_resp),
    .mst_req_o      (mst_req),
    .mst_resp_i     (mst_resp),
    .drain_req_i    (drain_req),
    .drain_ack_o    (drain_ack),
    .rd_cnt_o       (rd_cnt),
`ifdef WT_AXI_TXN_LIMITER_PERF_EN
    .rd_stall_cnt_o (rd_stall),
    .wr_stall_cnt_o (wr_stall),
`endif
    .wr_cnt_o       (wr_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    slv_req   = '0;
    mst_resp  = '0;
    drain_req = 1'b0;
    slv_req.r_ready = 1'b1;
    slv_req.b_ready = 1'b1;
    do_reset();

    chk("rst_rd_cnt", rd_cnt, 0);
    chk("rst_wr_cnt", wr_cnt, 0);
    chk("rst_ack", drain_ack, 0);
    chk("rst_ar_valid", mst_req.ar_valid, 0);

    // payload pass-through
    slv_req.ar.addr  = 64'h1234_5678;
    slv_req.w.data   = 64'hCAFE;
    slv_req.w_valid  = 1'b1;
    mst_resp.r.data  = 64'hBEEF;
    mst_resp.w_ready = 1'b1;
    #1;
    chk("pt_ar_addr", mst_req.ar.addr, 64'h1234_5678);
    chk("pt_w_data", mst_req.w.data, 64'hCAFE);
    chk("pt_w_valid", mst_req.w_valid, 1);
    chk("pt_r_data", slv_resp.r.data, 64'hBEEF);
    chk("pt_w_ready", slv_resp.w_ready, 1);
    slv_req.w_valid  = 1'b0;
    mst_resp.w_ready = 1'b0;

    // limit: three back-to-back ARs, R withheld
    slv_req.ar_valid  = 1'b1;
    mst_resp.ar_ready = 1'b1;
    #1;
    chk("lim_ar1_valid", mst_req.ar_valid, 1);
    tick();
    chk("lim_cnt1", rd_cnt, 1);
    chk("lim_ar2_valid", mst_req.ar_valid, 1);
    tick();
    chk("lim_cnt2", rd_cnt, 2);
    chk("lim_ar3_held", mst_req.ar_valid, 0);
    chk("lim_ar3_rdy", slv_resp.ar_ready, 0);
    tick();
    chk("lim_cnt2_hold", rd_cnt, 2);
    chk("lim_ar3_still_held", mst_req.ar_valid, 0);
    mst_resp.r_valid  = 1'b1;
    mst_resp.r.last   = 1'b1;
    tick();
    mst_resp.r_valid  = 1'b0;
    #1;
    chk("lim_cnt_after_r", rd_cnt, 1);
    chk("lim_ar3_issues", mst_req.ar_valid, 1);
    tick();
    chk("lim_cnt_after_ar3", rd_cnt, 2);

    // same-cycle inc/dec at count 1
    slv_req.ar_valid = 1'b0;
    mst_resp.r_valid = 1'b1;
    tick();
    chk("sc_cnt1", rd_cnt, 1);
    slv_req.ar_valid = 1'b1;
    tick();
    chk("sc_cnt_stays1", rd_cnt, 1);
    slv_req.ar_valid = 1'b0;
    tick();
    chk("sc_cnt0", rd_cnt, 0);
    mst_resp.r_valid = 1'b0;

    // stability: AR stalled downstream while drain arrives
    mst_resp.ar_ready = 1'b0;
    slv_req.ar_valid  = 1'b1;
    #1;
    chk("stab_c1", mst_req.ar_valid, 1);
    tick();
    drain_req = 1'b1;
    #1;
    chk("stab_c2", mst_req.ar_valid, 1);
    tick();
    chk("stab_c3", mst_req.ar_valid, 1);
    tick();
    chk("stab_c4", mst_req.ar_valid, 1);
    mst_resp.ar_ready = 1'b1;
    #1;
    chk("stab_slv_rdy", slv_resp.ar_ready, 1);
    tick();
    chk("stab_blocked_after_hs", mst_req.ar_valid, 0);
    chk("stab_cnt", rd_cnt, 1);
    chk("stab_no_ack", drain_ack, 0);
    mst_resp.r_valid = 1'b1;
    tick();
    chk("stab_ack", drain_ack, 1);
    chk("stab_cnt0", rd_cnt, 0);
    mst_resp.r_valid = 1'b0;
    slv_req.ar_valid = 1'b0;
    drain_req = 1'b0;
    tick();
    chk("stab_ack_drop", drain_ack, 0);

    // drain with 2 reads + 1 write outstanding
    slv_req.ar_valid  = 1'b1;
    slv_req.aw_valid  = 1'b1;
    mst_resp.aw_ready = 1'b1;
    tick();
    slv_req.aw_valid  = 1'b0;
    tick();
    slv_req.ar_valid  = 1'b0;
    #1;
    chk("dr_rd_cnt", rd_cnt, 2);
    chk("dr_wr_cnt", wr_cnt, 1);
    drain_req = 1'b1;
    tick();
    slv_req.ar_valid = 1'b1;
    slv_req.aw_valid = 1'b1;
    #1;
    chk("dr_ar_blocked", mst_req.ar_valid, 0);
    chk("dr_aw_blocked", mst_req.aw_valid, 0);
    chk("dr_aw_rdy_blocked", slv_resp.aw_ready, 0);
    mst_resp.r_valid = 1'b1;
    tick();
    tick();
    mst_resp.r_valid = 1'b0;
    mst_resp.b_valid = 1'b1;
    #1;
    chk("dr_rd_cnt0", rd_cnt, 0);
    chk("dr_no_ack_yet", drain_ack, 0);
    tick();
    mst_resp.b_valid = 1'b0;
    #1;
    chk("dr_ack", drain_ack, 1);
    chk("dr_wr_cnt0", wr_cnt, 0);
    chk("dr_idle_aw_blocked", mst_req.aw_valid, 0);
    drain_req = 1'b0;
    tick();
    chk("dr_ack_drop", drain_ack, 0);
    chk("dr_run_aw_passes", mst_req.aw_valid, 1);
    tick();
    slv_req.ar_valid = 1'b0;
    slv_req.aw_valid = 1'b0;
    #1;
    chk("ab_rd_cnt", rd_cnt, 1);
    chk("ab_wr_cnt", wr_cnt, 1);

    // abort: short drain pulse with traffic outstanding
    drain_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ab_no_ack", drain_ack, 0);
    end
    drain_req = 1'b0;
    tick();
    chk("ab_no_ack_after", drain_ack, 0);
    slv_req.ar_valid = 1'b1;
    #1;
    chk("ab_back_to_run", mst_req.ar_valid, 1);
    slv_req.ar_valid = 1'b0;

    // drain with nothing outstanding
    mst_resp.r_valid = 1'b1;
    mst_resp.b_valid = 1'b1;
    tick();
    mst_resp.r_valid = 1'b0;
    mst_resp.b_valid = 1'b0;
    #1;
    chk("zd_rd0", rd_cnt, 0);
    chk("zd_wr0", wr_cnt, 0);
    drain_req = 1'b1;
    tick();
    chk("zd_ack_c1", drain_ack, 0);
    tick();
    chk("zd_ack_c2", drain_ack, 1);
    drain_req = 1'b0;
    tick();
    chk("zd_ack_drop", drain_ack, 0);

`ifdef WT_AXI_TXN_LIMITER_PERF_EN
    do_reset();
    chk("perf_rst", rd_stall, 0);
    slv_req.ar_valid = 1'b1;
    tick();
    tick();
    chk("perf_none_yet", rd_stall, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("perf_five", rd_stall, 5);
    chk("perf_wr_zero", wr_stall, 0);
    slv_req.ar_valid = 1'b0;
    do_reset();
    chk("perf_rst_again", rd_stall, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
